burst_ram_initiator: RTL and testbench

Initiator for the BurstRAM command interface: converts one whole-line request (BURST_COUNT words) from a cache or core into a single BurstRAM read or write burst. It drives cmd/cmd_en/addr/wr_data/data_mask and collects rd_data beats qualified by rd_data_valid. It sits between the line consumer and the BurstRAM instance, so no client has to track burst beats or read latency.

---
 rtl/burst_ram_initiator.sv | 146 ++++++++++++++
 tb/tb_burst_ram_initiator.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/burst_ram_initiator.sv
// burst_ram_initiator: turns one whole-line request into a single BurstRAM
// read or write burst, sequencing write beats and collecting read beats.
module burst_ram_initiator #(
  parameter int DATA_BITWIDTH  = 64,
  parameter int BURST_COUNT    = 4,
  parameter int ADDR_BITWIDTH  = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   line_en,
  input  logic                                   line_cmd,
  input  logic [ADDR_BITWIDTH-1:0]               line_addr,
  input  logic [BURST_COUNT*DATA_BITWIDTH-1:0]   line_wr_data,
  input  logic [BURST_COUNT*DATA_BITWIDTH/8-1:0] line_wr_mask,
  output logic                                   line_ready,
  output logic [BURST_COUNT*DATA_BITWIDTH-1:0]   line_rd_data,
  output logic                                   line_done,
  output logic                                   line_error,
  output logic                                   cmd,
  output logic                                   cmd_en,
  output logic [ADDR_BITWIDTH-1:0]               addr,
  output logic [DATA_BITWIDTH-1:0]               wr_data,
  output logic [DATA_BITWIDTH/8-1:0]             data_mask,
  input  logic [DATA_BITWIDTH-1:0]               rd_data,
  input  logic                                   rd_data_valid,
  input  logic                                   busy
);
  localparam int DW = DATA_BITWIDTH;
  localparam int BW = DATA_BITWIDTH / 8;
  localparam int LW = BURST_COUNT * DATA_BITWIDTH;
  localparam int MW = LW / 8;
  localparam int CW = (BURST_COUNT > 1) ? $clog2(BURST_COUNT) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_COUNT - 1);
  localparam logic [TW-1:0] LAST_TMO  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_READ
  } state_t;

  state_t             r_state;
  logic               r_cmd;
  logic               r_cmd_en;
  logic [ADDR_BITWIDTH-1:0] r_addr;
  logic [DW-1:0]      r_wr_data;
  logic [BW-1:0]      r_data_mask;
  logic [LW-1:0]      r_line_rd_data;
  logic               r_line_done;
  logic               r_line_error;
  logic [LW-1:0]      r_wr_line;
  logic [MW-1:0]      r_wr_mask;
  logic [CW-1:0]      r_beat;
  logic [TW-1:0]      r_tmo;
  logic [CW-1:0]      w_nxt;
  logic               w_ready;

  assign w_nxt        = r_beat + 1'b1;
  assign w_ready      = (r_state == S_IDLE) && !busy;
  assign line_ready   = w_ready;
  assign line_rd_data = r_line_rd_data;
  assign line_done    = r_line_done;
  assign line_error   = r_line_error;
  assign cmd          = r_cmd;
  assign cmd_en       = r_cmd_en;
  assign addr         = r_addr;
  assign wr_data      = r_wr_data;
  assign data_mask    = r_data_mask;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_cmd          <= 1'b0;
      r_cmd_en       <= 1'b0;
      r_addr         <= '0;
      r_wr_data      <= '0;
      r_data_mask    <= '0;
      r_line_rd_data <= '0;
      r_line_done    <= 1'b0;
      r_line_error   <= 1'b0;
      r_wr_line      <= '0;
      r_wr_mask      <= '0;
      r_beat         <= '0;
      r_tmo          <= '0;
    end else begin
      r_line_done  <= 1'b0;
      r_line_error <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (line_en && w_ready) begin
            r_cmd_en  <= 1'b1;
            r_cmd     <= line_cmd;
            r_addr    <= line_addr;
            r_beat    <= '0;
            r_tmo     <= '0;
            r_wr_line <= line_wr_data;
            r_wr_mask <= line_wr_mask;
            if (line_cmd) begin
              r_wr_data   <= line_wr_data[DW-1:0];
              r_data_mask <= line_wr_mask[BW-1:0];
              r_state     <= S_WRITE;
            end else begin
              r_line_rd_data <= '0;
              r_state        <= S_READ;
            end
          end
        end
        S_WRITE: begin
          r_cmd_en <= 1'b0;
          r_cmd    <= 1'b0;
          if (r_beat == LAST_BEAT) begin
            r_line_done <= 1'b1;
            r_wr_data   <= '0;
            r_data_mask <= '0;
            r_state     <= S_IDLE;
          end else begin
            r_beat      <= w_nxt;
            r_wr_data   <= r_wr_line[int'(w_nxt)*DW +: DW];
            r_data_mask <= r_wr_mask[int'(w_nxt)*BW +: BW];
          end
        end
        S_READ: begin
          r_cmd_en <= 1'b0;
          r_cmd    <= 1'b0;
          r_tmo    <= r_tmo + 1'b1;
          if (rd_data_valid) begin
            r_line_rd_data[int'(r_beat)*DW +: DW] <= rd_data;
            r_beat <= w_nxt;
          end
          // a last beat arriving on the timeout edge still counts as success
          if (rd_data_valid && r_beat == LAST_BEAT) begin
            r_line_done <= 1'b1;
            r_state     <= S_IDLE;
          end else if (r_tmo == LAST_TMO) begin
            r_line_done  <= 1'b1;
            r_line_error <= 1'b1;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_burst_ram_initiator.sv
// Bench for burst_ram_initiator: behavioural BurstRAM, reference memory
// and a queue of expected read lines.
module tb_burst_ram_initiator;
  localparam logic [255:0] L0 =
    256'h7D4E9F2C1B6A3D8F_A1C3F7E2D5B8A9C4_9D8E2F17AB4C3E6F_3F5A2E14B7C6A980;
  localparam logic [255:0] L1 =
    256'h0123456789ABCDEF_FEDCBA9876543210_DEADBEEFCAFEF00D_1122334455667788;
  localparam logic [255:0] L2 =
    256'hAAAAAAAAAAAAAAAA_BBBBBBBBBBBBBBBB_CCCCCCCCCCCCCCCC_DDDDDDDDDDDDDDDD;
  localparam logic [255:0] L3 =
    256'h5555AAAA5555AAAA_0F0F0F0F0F0F0F0F_F0F0F0F0F0F0F0F0_9999888877776666;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         line_en = 1'b0;
  logic         line_cmd = 1'b0;
  logic [3:0]   line_addr = '0;
  logic [255:0] line_wr_data = '0;
  logic [31:0]  line_wr_mask = '0;
  logic         line_ready;
  logic [255:0] line_rd_data;
  logic         line_done;
  logic         line_error;
  logic         cmd;
  logic         cmd_en;
  logic [3:0]   addr;
  logic [63:0]  wr_data;
  logic [7:0]   data_mask;
  logic [63:0]  rd_data = '0;
  logic         rd_data_valid = 1'b0;
  logic         busy = 1'b0;

  int total = 0;
  int bad = 0;
  logic [255:0] sb[$];

  burst_ram_initiator #(
    .DATA_BITWIDTH(64),
    .BURST_COUNT(4),
    .ADDR_BITWIDTH(4),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst),
    .line_en(line_en), .line_cmd(line_cmd),
    .line_addr(line_addr), .line_wr_data(line_wr_data),
    .line_wr_mask(line_wr_mask), .line_ready(line_ready),
    .line_rd_data(line_rd_data), .line_done(line_done),
    .line_error(line_error), .cmd(cmd), .cmd_en(cmd_en),
    .addr(addr), .wr_data(wr_data), .data_mask(data_mask),
    .rd_data(rd_data), .rd_data_valid(rd_data_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] merge(logic [63:0] o, logic [63:0] d,
                                        logic [7:0] m);
    merge = o;
    for (int i = 0; i < 8; i++)
      if (!m[i]) merge[8*i +: 8] = d[8*i +: 8];
  endfunction

  // behavioural BurstRAM: latency 4, optional gaps, optional mute
  logic [63:0] mem [16];
  logic [63:0] ref_mem [16];
  logic [3:0]  waddr = '0, wb = '0, raddr = '0, rb = '0;
  int          wcnt = 0, rcnt = 0, lat = 0;
  logic        ph = 1'b0, gap = 1'b0, mute = 1'b0;

  initial
    for (int i = 0; i < 16; i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end

  always @(posedge clk) begin
    rd_data_valid <= 1'b0;
    ph <= ~ph;
    if (wcnt != 0) begin
      mem[4'(waddr + wb)] <= merge(mem[4'(waddr + wb)], wr_data, data_mask);
      wb   <= wb + 4'd1;
      wcnt <= wcnt - 1;
    end
    if (cmd_en && cmd) begin
      mem[addr] <= merge(mem[addr], wr_data, data_mask);
      waddr <= addr;
      wb    <= 4'd1;
      wcnt  <= 3;
    end
    if (cmd_en && !cmd && !mute) begin
      raddr <= addr;
      rb    <= '0;
      lat   <= 3;
    end else if (lat != 0) begin
      lat <= lat - 1;
      if (lat == 1) rcnt <= 4;
    end
    if (rcnt != 0 && !(gap && ph)) begin
      rd_data_valid <= 1'b1;
      rd_data <= mem[4'(raddr + rb)];
      rb   <= rb + 4'd1;
      rcnt <= rcnt - 1;
    end
  end

  task automatic chk(string tag, logic [255:0] obs, logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic ref_write(logic [3:0] a, logic [255:0] d, logic [31:0] m);
    for (int k = 0; k < 4; k++)
      ref_mem[4'(a + k)] = merge(ref_mem[4'(a + k)], d[64*k +: 64], m[8*k +: 8]);
  endtask

  function automatic logic [255:0] ref_line(logic [3:0] a);
    ref_line = '0;
    for (int k = 0; k < 4; k++) ref_line[64*k +: 64] = ref_mem[4'(a + k)];
  endfunction

  // caller is positioned at a negedge; request is accepted at the next posedge
  task automatic do_write(logic [3:0] a, logic [255:0] d, logic [31:0] m);
    line_en = 1'b1; line_cmd = 1'b1;
    line_addr = a; line_wr_data = d; line_wr_mask = m;
    @(negedge clk);
    line_en = 1'b0;
    chk("wr_cmd_en", cmd_en, 1);
    chk("wr_cmd", cmd, 1);
    chk("wr_addr", addr, a);
    chk("wr_beat0", wr_data, d[63:0]);
    chk("wr_mask0", data_mask, m[7:0]);
    ref_write(a, d, m);
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      chk("wr_cmd_en_drop", cmd_en, 0);
      chk("wr_beat", wr_data, d[64*k +: 64]);
      chk("wr_mask", data_mask, m[8*k +: 8]);
      chk("wr_done_early", line_done, 0);
    end
    @(negedge clk);
    chk("wr_done", line_done, 1);
    chk("wr_data_idle", wr_data, 0);
    chk("wr_ready_on_done", line_ready, 1);
  endtask

  task automatic do_read(logic [3:0] a, bit exp_err, int exp_lat);
    int n;
    logic [255:0] e;
    line_en = 1'b1; line_cmd = 1'b0; line_addr = a;
    @(negedge clk);
    line_en = 1'b0;
    chk("rd_cmd_en", cmd_en, 1);
    chk("rd_cmd", cmd, 0);
    chk("rd_addr", addr, a);
    sb.push_back(exp_err ? 256'd0 : ref_line(a));
    n = 0;
    while (n < 60 && !line_done) begin
      @(negedge clk);
      n++;
    end
    chk("rd_done", line_done, 1);
    if (exp_lat != 0) chk("rd_latency", n, exp_lat);
    e = sb.pop_front();
    chk("rd_line", line_rd_data, e);
    chk("rd_error", line_error, exp_err);
    @(negedge clk);
    chk("rd_hold", line_rd_data, e);
    chk("rd_done_pulse", line_done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    chk("rst_cmd_en", cmd_en, 0);
    chk("rst_outs", {cmd, addr, wr_data, data_mask, line_done, line_error}, 0);
    chk("rst_line", line_rd_data, 0);
    chk("rst_ready", line_ready, 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    do_write(4'd0, L0, 32'h0);
    do_write(4'd4, L1, 32'h0);
    do_read(4'd0, 1'b0, 9);
    do_read(4'd4, 1'b0, 9);

    do_write(4'd0, L2, 32'h0000FF00);
    do_read(4'd0, 1'b0, 9);

    busy = 1'b1;
    line_en = 1'b1; line_cmd = 1'b1;
    line_addr = 4'd8; line_wr_data = L3; line_wr_mask = '0;
    repeat (10) begin
      @(negedge clk);
      chk("busy_ready", line_ready, 0);
      chk("busy_cmd_en", cmd_en, 0);
    end
    busy = 1'b0;
    do_write(4'd8, L3, 32'h0);
    do_read(4'd8, 1'b0, 9);

    gap = 1'b1;
    do_read(4'd4, 1'b0, 0);
    gap = 1'b0;

    mute = 1'b1;
    do_read(4'd0, 1'b1, 16);
    mute = 1'b0;

    line_en = 1'b1; line_cmd = 1'b1;
    line_addr = 4'd12; line_wr_data = L1; line_wr_mask = '0;
    @(negedge clk);
    line_en = 1'b0;
    rst = 1'b1;
    #1;
    chk("rstw_cmd_en", cmd_en, 0);
    chk("rstw_wr_data", wr_data, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    do_read(4'd12, 1'b0, 9);

    line_en = 1'b1; line_cmd = 1'b0; line_addr = 4'd0;
    @(negedge clk);
    line_en = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rstr_line", line_rd_data, 0);
    chk("rstr_outs", {cmd_en, cmd, addr, wr_data, data_mask, line_done, line_error}, 0);
    chk("rstr_ready", line_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rstr_no_done", line_done, 0);
    end
    repeat (6) @(negedge clk);
    do_read(4'd0, 1'b0, 9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
